hdlc_rx_checker: RTL and testbench
==================================

Name: hdlc_rx_checker

Overview:
- Synthesizable run-time protocol checker for the HDLC receive path; replaces simulation-only concurrent assertions with counters and sticky flags readable in silicon or emulation.
- Sits beside the Rx block and taps the serial line and Rx status strobes.
- Generalised: parametrised flag latency, maximum frame size, counter width and per-check enable mask.
- Adds a frame-tracking FSM and a saturating error counter.

Parameters:
- FLAG_LAT, 2, cycles from last pattern bit on Rx to Rx_FlagDetect/Rx_AbortDetect (legal 1..4)
- MAX_FRAME_BYTES, 128, bytes per frame before Rx_Overflow is required
- ERR_CNT_W, 16, width of ErrCnt
- CHK_MASK, 6'b111111, static enable per check, bit index = check id

Ports:
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  synchronous reset, active-high
- Mon_En  in  1  run-time check enable
- Clr  in  1  clears ErrFlags and ErrCnt
- Rx  in  1  serial receive line
- Rx_ValidFrame  in  1  frame in progress
- Rx_NewByte  in  1  byte strobe
- Rx_FlagDetect  in  1  receiver flag detect
- Rx_AbortDetect  in  1  receiver abort detect
- Rx_AbortSignal  in  1  receiver abort status
- Rx_EoF  in  1  end-of-frame strobe
- Rx_Overflow  in  1  overflow status
- Rx_Ready  in  1  buffer ready status
- ErrFlags  out  6  sticky per-check failure bits
- ErrCnt  out  ERR_CNT_W  saturating failure count
- ErrPulse  out  1  high for one cycle in any cycle with at least one failure
- FrameBytes  out  8  bytes counted in current/last frame, saturating

Behaviour:
- Reset: ErrFlags=0, ErrCnt=0, ErrPulse=0, FrameBytes=0, FSM=IDLE, shift register=8'hFF, delay lines=0.
- Shift register sr <= {sr[6:0],Rx} every cycle.
- FLAG_HIT is sr==8'b0111_1110 after update. ABORT_HIT is sr==8'b0111_1111. Eight ones never produce ABORT_HIT (leading 0 required).
- Each hit enters a FLAG_LAT-deep delay line. Hits are generated every cycle regardless of Mon_En.
- Checks. A failure is evaluated only when Mon_En=1 and CHK_MASK[id]=1:
  - 0 FLAG: delayed FLAG_HIT != Rx_FlagDetect, in either direction.
  - 1 ABORT: delayed ABORT_HIT=1 and Rx_AbortDetect=0.
  - 2 ABORTSIG: Rx_ValidFrame&&Rx_AbortDetect at t, and Rx_AbortSignal=0 at t+1.
  - 3 EOF: Rx_ValidFrame falls at t, and Rx_EoF=0 at t+1.
  - 4 OVF: in IN_FRAME, the (MAX_FRAME_BYTES+1)th Rx_NewByte at t, and Rx_Overflow=0 at t+1.
  - 5 READY: Rx_Ready rises, and Rx_EoF=0 or Rx_ValidFrame=1 in that cycle.
- FSM:
  - IDLE -> IN_FRAME on Rx_ValidFrame rise; byte count cleared on entry.
  - IN_FRAME counts Rx_NewByte, saturating at 255.
  - IN_FRAME -> EOF_WAIT on Rx_ValidFrame fall.
  - EOF_WAIT -> IDLE next cycle, evaluating check 3. If Rx_ValidFrame rises in that cycle, go to IN_FRAME instead.
  - FrameBytes holds its value in IDLE.
- Failure reporting:
  - ErrFlags[id] is set on failure and registered, so it is visible the cycle after the failure condition.
  - ErrCnt adds the popcount of simultaneous failures and saturates at all-ones.
  - ErrPulse is registered with the same timing as ErrFlags.
- Clr has priority over new failures in the same cycle; failures in that cycle are dropped.
- Mon_En=0: checks are suppressed; FSM, counters and delay lines keep running.
- Rst mid-frame: everything returns to reset values; the FSM starts in IDLE even if Rx_ValidFrame=1 (no rise is seen, so the frame is not tracked).

Optional Feature:
- Macro HDLC_RX_CHECKER_FIRSTERR_EN.
- Defined: adds outputs FirstErrId (3) and FirstErrTime (32).
  - A free-running cycle counter runs from reset.
  - On the first failure after Rst/Clr, the lowest failing id and the counter value are captured and held.
  - FirstErrId=3'b111 means no failure has been captured.
- Undefined: these ports, the cycle counter and the capture logic are absent.

Test Plan:
- Idle 8'hFF then Rx bits 0,1,1,1,1,1,1,0 with Rx_FlagDetect pulsed 2 cycles after the last bit -> ErrFlags=0, ErrCnt=0.
- Same flag with Rx_FlagDetect pulsed 3 cycles after -> ErrFlags[0]=1, ErrCnt=2 (one miss, one spurious), ErrPulse twice.
- Frame of 129 Rx_NewByte with Rx_Overflow high the cycle after the 129th byte -> no error, FrameBytes=129. With Rx_Overflow held low -> ErrFlags[4]=1, ErrCnt=1.
- Rx_ValidFrame falls with Rx_EoF delayed one extra cycle -> ErrFlags[3]=1. Then Clr pulsed -> ErrFlags=0, ErrCnt=0.
- Rx_ValidFrame=1 and Rx_AbortDetect=1 with Rx_AbortSignal stuck at 0, plus a simultaneous Rx_Ready rise without Rx_EoF -> ErrFlags[2] and ErrFlags[5] set, ErrCnt=2. Repeat with Mon_En=0 -> no change.
- Set ERR_CNT_W=4 and inject 20 failures -> ErrCnt=15 (saturated). Assert Rst mid-frame -> all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/hdlc_rx_checker.sv
// hdlc_rx_checker: run-time HDLC Rx protocol checker with sticky flags, saturating error count and frame tracking.
// Optional first-error capture (FirstErrId/FirstErrTime) is enabled by defining HDLC_RX_CHECKER_FIRSTERR_EN.
module hdlc_rx_checker #(
  parameter int         FLAG_LAT        = 2,
  parameter int         MAX_FRAME_BYTES = 128,
  parameter int         ERR_CNT_W       = 16,
  parameter logic [5:0] CHK_MASK        = 6'b111111
)(
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Mon_En,
  input  logic                 Clr,
  input  logic                 Rx,
  input  logic                 Rx_ValidFrame,
  input  logic                 Rx_NewByte,
  input  logic                 Rx_FlagDetect,
  input  logic                 Rx_AbortDetect,
  input  logic                 Rx_AbortSignal,
  input  logic                 Rx_EoF,
  input  logic                 Rx_Overflow,
  input  logic                 Rx_Ready,
  output logic [5:0]           ErrFlags,
  output logic [ERR_CNT_W-1:0] ErrCnt,
  output logic                 ErrPulse,
`ifdef HDLC_RX_CHECKER_FIRSTERR_EN
  output logic [7:0]           FrameBytes,
  output logic [2:0]           FirstErrId,
  output logic [31:0]          FirstErrTime
`else
  output logic [7:0]           FrameBytes
`endif
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] IN_FRAME = 2'd1;
  localparam logic [1:0] EOF_WAIT = 2'd2;
  typedef logic [FLAG_LAT-1:0] dl_t;
  logic [7:0] sr_q, sr_d;
  dl_t flag_dl_q, abort_dl_q;
  logic flag_hit, abort_hit, vf_q, ready_q, vf_rise, vf_fall, ovf_hit;
  logic abort_arm_q, ovf_arm_q, pulse_q;
  logic [1:0] st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] fail, flags_q;
  logic [2:0] pop;
  logic [ERR_CNT_W+2:0] sum;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  always_comb begin
    sr_d      = {sr_q[6:0], Rx};
    flag_hit  = sr_d == 8'b0111_1110;
    abort_hit = sr_d == 8'b0111_1111;
    vf_rise   = Rx_ValidFrame & ~vf_q;
    vf_fall   = ~Rx_ValidFrame & vf_q;
    ovf_hit   = (st_q == IN_FRAME) && Rx_NewByte && (cnt_q == 8'(MAX_FRAME_BYTES));
    fail      = {Rx_Ready & ~ready_q & (~Rx_EoF | Rx_ValidFrame),
                 ovf_arm_q & ~Rx_Overflow,
                 (st_q == EOF_WAIT) & ~Rx_EoF,
                 abort_arm_q & ~Rx_AbortSignal,
                 abort_dl_q[FLAG_LAT-1] & ~Rx_AbortDetect,
                 flag_dl_q[FLAG_LAT-1] ^ Rx_FlagDetect} & CHK_MASK & {6{Mon_En}};
    st_d      = (st_q == IN_FRAME) ? (vf_fall ? EOF_WAIT : IN_FRAME) : (vf_rise ? IN_FRAME : IDLE);
    cnt_d     = (st_q != IN_FRAME && vf_rise) ? 8'd0 :
                (st_q == IN_FRAME && Rx_NewByte && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    pop       = 3'($countones(fail));
    sum       = {3'b000, err_cnt_q} + {{ERR_CNT_W{1'b0}}, pop};
    err_cnt_d = Clr ? '0 : (|sum[ERR_CNT_W+2:ERR_CNT_W]) ? '1 : sum[ERR_CNT_W-1:0];
  end
  always_ff @(posedge Clk) begin
    // Edge detectors track the line through reset so a level held across reset is not seen as a new edge
    vf_q    <= Rx_ValidFrame;
    ready_q <= Rx_Ready;
    if (Rst) begin
      sr_q        <= 8'hFF;
      flag_dl_q   <= '0;
      abort_dl_q  <= '0;
      abort_arm_q <= 1'b0;
      ovf_arm_q   <= 1'b0;
      st_q        <= IDLE;
      cnt_q       <= 8'd0;
      flags_q     <= 6'd0;
      err_cnt_q   <= '0;
      pulse_q     <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      flag_dl_q   <= dl_t'({flag_dl_q, flag_hit});
      abort_dl_q  <= dl_t'({abort_dl_q, abort_hit});
      abort_arm_q <= Rx_ValidFrame & Rx_AbortDetect;
      ovf_arm_q   <= ovf_hit;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      flags_q     <= Clr ? 6'd0 : flags_q | fail;
      err_cnt_q   <= err_cnt_d;
      pulse_q     <= ~Clr & (|fail);
    end
  end
  assign ErrFlags   = flags_q;
  assign ErrCnt     = err_cnt_q;
  assign ErrPulse   = pulse_q;
  assign FrameBytes = cnt_q;
`ifdef HDLC_RX_CHECKER_FIRSTERR_EN
  logic [31:0] cyc_q, first_t_q;
  logic [2:0] first_id_q, low_id;
  always_comb begin
    low_id = 3'd7;
    for (int i = 5; i >= 0; i--) low_id = fail[i] ? 3'(i) : low_id;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cyc_q      <= 32'd0;
      first_id_q <= 3'b111;
      first_t_q  <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (Clr) begin
        first_id_q <= 3'b111;
        first_t_q  <= 32'd0;
      end else if (first_id_q == 3'b111 && |fail) begin
        first_id_q <= low_id;
        first_t_q  <= cyc_q;
      end
    end
  end
  assign FirstErrId   = first_id_q;
  assign FirstErrTime = first_t_q;
`endif
endmodule

// File: tb/tb_hdlc_rx_checker.sv
// tb_hdlc_rx_checker: directed self-checking bench for hdlc_rx_checker (ERR_CNT_W=4, FLAG_LAT=2, MAX_FRAME_BYTES=128).
module tb_hdlc_rx_checker;
  logic Clk = 1'b0;
  logic Rst, Mon_En, Clr, Rx, Rx_ValidFrame, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect;
  logic Rx_AbortSignal, Rx_EoF, Rx_Overflow, Rx_Ready;
  logic [5:0] ErrFlags;
  logic [3:0] ErrCnt;
  logic ErrPulse;
  logic [7:0] FrameBytes;
  int errors = 0;
  int checks = 0;
  int pulses = 0;
`ifdef HDLC_RX_CHECKER_FIRSTERR_EN
  logic [2:0] FirstErrId;
  logic [31:0] FirstErrTime;
`endif

  always #5 Clk = ~Clk;

  hdlc_rx_checker #(.ERR_CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .Mon_En(Mon_En), .Clr(Clr), .Rx(Rx),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_NewByte(Rx_NewByte), .Rx_FlagDetect(Rx_FlagDetect),
    .Rx_AbortDetect(Rx_AbortDetect), .Rx_AbortSignal(Rx_AbortSignal), .Rx_EoF(Rx_EoF),
    .Rx_Overflow(Rx_Overflow), .Rx_Ready(Rx_Ready),
    .ErrFlags(ErrFlags), .ErrCnt(ErrCnt), .ErrPulse(ErrPulse),
`ifdef HDLC_RX_CHECKER_FIRSTERR_EN
    .FrameBytes(FrameBytes), .FirstErrId(FirstErrId), .FirstErrTime(FirstErrTime)
`else
    .FrameBytes(FrameBytes)
`endif
  );

  task automatic tick();
    @(posedge Clk);
    #1;
    pulses += int'(ErrPulse);
  endtask

  task automatic do_clr();
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    pulses = 0;
  endtask

  // Bit i of each vector is driven in cycle i; Rx idles high afterwards
  task automatic line(input logic [31:0] rx, input logic [31:0] fd, input logic [31:0] ad);
    for (int i = 0; i < 32; i++) begin
      Rx = rx[i];
      Rx_FlagDetect = fd[i];
      Rx_AbortDetect = ad[i];
      tick();
    end
    Rx = 1'b1;
    Rx_FlagDetect = 1'b0;
    Rx_AbortDetect = 1'b0;
  endtask

  task automatic frame(input int n, input logic ovf, input logic eof_ok);
    Rx_ValidFrame = 1'b1;
    tick();
    Rx_NewByte = 1'b1;
    repeat (n) tick();
    Rx_NewByte = 1'b0;
    Rx_Overflow = ovf;
    tick();
    Rx_Overflow = 1'b0;
    Rx_ValidFrame = 1'b0;
    tick();
    if (!eof_ok) tick();
    Rx_EoF = 1'b1;
    tick();
    Rx_EoF = 1'b0;
    tick();
  endtask

  task automatic abortsig_seq();
    Rx_ValidFrame = 1'b1;
    tick();
    tick();
    Rx_AbortDetect = 1'b1;
    Rx_Ready = 1'b1;
    tick();
    Rx_AbortDetect = 1'b0;
    tick();
    Rx_Ready = 1'b0;
    Rx_ValidFrame = 1'b0;
    tick();
    Rx_EoF = 1'b1;
    tick();
    Rx_EoF = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    checks++; if (ErrFlags !== 6'd0) begin errors++; $display("FAIL reset_flags: got %h expected %h", ErrFlags, 6'd0); end
    checks++; if (ErrCnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", ErrCnt); end
    checks++; if (ErrPulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", ErrPulse); end
    checks++; if (FrameBytes !== 8'd0) begin errors++; $display("FAIL reset_bytes: got %0d expected 0", FrameBytes); end
`ifdef HDLC_RX_CHECKER_FIRSTERR_EN
    checks++; if (FirstErrId !== 3'b111) begin errors++; $display("FAIL reset_firstid: got %0d expected 7", FirstErrId); end
`endif
  endtask

  task automatic test_flag_ok();
    do_clr();
    line(32'hFFFF_FF7E, 32'h0000_0200, 32'h0001_0000);
    checks++; if (ErrFlags !== 6'd0) begin errors++; $display("FAIL flag_ok_flags: got %h expected %h", ErrFlags, 6'd0); end
    checks++; if (ErrCnt !== 4'd0) begin errors++; $display("FAIL flag_ok_cnt: got %0d expected 0", ErrCnt); end
  endtask

  task automatic test_flag_late();
    do_clr();
    line(32'hFFFF_FF7E, 32'h0000_0400, 32'h0001_0000);
    checks++; if (ErrFlags !== 6'h01) begin errors++; $display("FAIL flag_late_flags: got %h expected %h", ErrFlags, 6'h01); end
    checks++; if (ErrCnt !== 4'd2) begin errors++; $display("FAIL flag_late_cnt: got %0d expected 2", ErrCnt); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL flag_late_pulses: got %0d expected 2", pulses); end
  endtask

  task automatic test_abort();
    do_clr();
    line(32'hFFFF_FF7E, 32'h0000_0200, 32'h0000_0000);
    checks++; if (ErrFlags !== 6'h02) begin errors++; $display("FAIL abort_flags: got %h expected %h", ErrFlags, 6'h02); end
    checks++; if (ErrCnt !== 4'd1) begin errors++; $display("FAIL abort_cnt: got %0d expected 1", ErrCnt); end
  endtask

  task automatic test_overflow();
    do_clr();
    frame(129, 1'b1, 1'b1);
    checks++; if (ErrFlags !== 6'd0) begin errors++; $display("FAIL ovf_ok_flags: got %h expected %h", ErrFlags, 6'd0); end
    checks++; if (ErrCnt !== 4'd0) begin errors++; $display("FAIL ovf_ok_cnt: got %0d expected 0", ErrCnt); end
    checks++; if (FrameBytes !== 8'd129) begin errors++; $display("FAIL ovf_ok_bytes: got %0d expected 129", FrameBytes); end
    do_clr();
    frame(129, 1'b0, 1'b1);
    checks++; if (ErrFlags !== 6'h10) begin errors++; $display("FAIL ovf_miss_flags: got %h expected %h", ErrFlags, 6'h10); end
    checks++; if (ErrCnt !== 4'd1) begin errors++; $display("FAIL ovf_miss_cnt: got %0d expected 1", ErrCnt); end
  endtask

  task automatic test_eof();
    do_clr();
    frame(2, 1'b0, 1'b0);
    checks++; if (ErrFlags !== 6'h08) begin errors++; $display("FAIL eof_flags: got %h expected %h", ErrFlags, 6'h08); end
    checks++; if (ErrCnt !== 4'd1) begin errors++; $display("FAIL eof_cnt: got %0d expected 1", ErrCnt); end
    checks++; if (FrameBytes !== 8'd2) begin errors++; $display("FAIL eof_bytes: got %0d expected 2", FrameBytes); end
    do_clr();
    checks++; if (ErrFlags !== 6'd0) begin errors++; $display("FAIL clr_flags: got %h expected %h", ErrFlags, 6'd0); end
    checks++; if (ErrCnt !== 4'd0) begin errors++; $display("FAIL clr_cnt: got %0d expected 0", ErrCnt); end
  endtask

  task automatic test_abortsig_ready();
    do_clr();
    abortsig_seq();
    checks++; if (ErrFlags !== 6'h24) begin errors++; $display("FAIL abortsig_flags: got %h expected %h", ErrFlags, 6'h24); end
    checks++; if (ErrCnt !== 4'd2) begin errors++; $display("FAIL abortsig_cnt: got %0d expected 2", ErrCnt); end
    do_clr();
    Mon_En = 1'b0;
    abortsig_seq();
    Mon_En = 1'b1;
    checks++; if (ErrFlags !== 6'd0) begin errors++; $display("FAIL monoff_flags: got %h expected %h", ErrFlags, 6'd0); end
    checks++; if (ErrCnt !== 4'd0) begin errors++; $display("FAIL monoff_cnt: got %0d expected 0", ErrCnt); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL monoff_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_clr_priority();
    do_clr();
    Clr = 1'b1;
    Rx_Ready = 1'b1;
    tick();
    Clr = 1'b0;
    Rx_Ready = 1'b0;
    tick();
    checks++; if (ErrFlags !== 6'd0) begin errors++; $display("FAIL clrprio_flags: got %h expected %h", ErrFlags, 6'd0); end
    checks++; if (ErrCnt !== 4'd0) begin errors++; $display("FAIL clrprio_cnt: got %0d expected 0", ErrCnt); end
    Rx_EoF = 1'b1;
    Rx_Ready = 1'b1;
    tick();
    Rx_EoF = 1'b0;
    Rx_Ready = 1'b0;
    tick();
    checks++; if (ErrFlags !== 6'd0) begin errors++; $display("FAIL ready_ok_flags: got %h expected %h", ErrFlags, 6'd0); end
    Rx_Ready = 1'b1;
    tick();
    Rx_Ready = 1'b0;
    tick();
    checks++; if (ErrFlags !== 6'h20) begin errors++; $display("FAIL ready_bad_flags: got %h expected %h", ErrFlags, 6'h20); end
  endtask

  task automatic test_saturation();
    do_clr();
    for (int i = 0; i < 20; i++) begin
      Rx_Ready = 1'b1;
      tick();
      Rx_Ready = 1'b0;
      tick();
      if (i == 13) begin
        checks++; if (ErrCnt !== 4'd14) begin errors++; $display("FAIL sat_mid_cnt: got %0d expected 14", ErrCnt); end
      end
    end
    checks++; if (ErrCnt !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d expected 15", ErrCnt); end
    checks++; if (ErrFlags !== 6'h20) begin errors++; $display("FAIL sat_flags: got %h expected %h", ErrFlags, 6'h20); end
    checks++; if (pulses !== 20) begin errors++; $display("FAIL sat_pulses: got %0d expected 20", pulses); end
  endtask

  task automatic test_rst_mid_frame();
    do_clr();
    Rx_ValidFrame = 1'b1;
    tick();
    Rx_NewByte = 1'b1;
    repeat (3) tick();
    Rx_NewByte = 1'b0;
    Rx_Ready = 1'b1;
    tick();
    Rx_Ready = 1'b0;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++; if (ErrFlags !== 6'd0) begin errors++; $display("FAIL rst_mid_flags: got %h expected %h", ErrFlags, 6'd0); end
    checks++; if (ErrCnt !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", ErrCnt); end
    checks++; if (ErrPulse !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse: got %b expected 0", ErrPulse); end
    checks++; if (FrameBytes !== 8'd0) begin errors++; $display("FAIL rst_mid_bytes: got %0d expected 0", FrameBytes); end
    Rx_NewByte = 1'b1;
    repeat (2) tick();
    Rx_NewByte = 1'b0;
    Rx_ValidFrame = 1'b0;
    repeat (3) tick();
    checks++; if (FrameBytes !== 8'd0) begin errors++; $display("FAIL rst_idle_bytes: got %0d expected 0", FrameBytes); end
    checks++; if (ErrFlags !== 6'd0) begin errors++; $display("FAIL rst_idle_flags: got %h expected %h", ErrFlags, 6'd0); end
  endtask

  initial begin
    Rst = 1'b1; Mon_En = 1'b1; Clr = 1'b0; Rx = 1'b1; Rx_ValidFrame = 1'b0; Rx_NewByte = 1'b0;
    Rx_FlagDetect = 1'b0; Rx_AbortDetect = 1'b0; Rx_AbortSignal = 1'b0; Rx_EoF = 1'b0;
    Rx_Overflow = 1'b0; Rx_Ready = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    test_reset();
    test_flag_ok();
    test_flag_late();
    test_abort();
    test_overflow();
    test_eof();
    test_abortsig_ready();
    test_clr_priority();
    test_saturation();
    test_rst_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
